// File: rtl/multicycle_sequencer_pkg.sv
// Shared definitions for the multi-cycle control path: FSM state encodings
// and the RV32I major opcodes that both the sequencer and decode unit use.
package multicycle_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEMORY    = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_HALT      = 3'd6
    } seq_state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // SYSTEM is deliberately absent: ecall halts cleanly rather than executing.
    function automatic logic is_legal_opcode(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_AUIPC, OP_LUI: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_sequencer_mem_wait_timer.sv
// Counts cycles spent waiting on a memory handshake and flags when the
// wait has reached MEM_TIMEOUT; shared by the fetch and data-memory stages.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic timed_out
);

    localparam int CNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

    logic [CNT_W-1:0] count;

    // Holds at the limit so the flag stays up until the owning state exits.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && !timed_out) begin
            count <= count + CNT_W'(1);
        end
    end

    assign timed_out = (count == CNT_W'(MEM_TIMEOUT));

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM: walks one instruction at a time through
// fetch/decode/execute/memory/writeback and gates the decode enables.
module multicycle_sequencer
    import multicycle_sequencer_pkg::*;
#(
    parameter int COUNT_BITS  = 32,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [6:0]            opcode,
    input  logic                  decode_wEn,
    input  logic                  decode_mem_wEn,
    input  logic                  imem_ready,
    input  logic                  dmem_ready,
    output logic                  imem_req,
    output logic                  ir_load,
    output logic                  dmem_req,
    output logic                  mem_wEn,
    output logic                  rf_wEn,
    output logic                  pc_load,
    output logic [2:0]            state,
    output logic                  halted,
    output logic                  fault,
    output logic [COUNT_BITS-1:0] cycle_count,
    output logic [COUNT_BITS-1:0] instret
);

    seq_state_t            state_q, state_next;
    logic                  fault_q, fault_set;
    logic [COUNT_BITS-1:0] cycle_count_q, instret_q;
    logic                  waiting, timed_out;
    logic                  imem_req_c, ir_load_c, dmem_req_c, mem_wEn_c, rf_wEn_c, pc_load_c;

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wait_timer (
        .clock    (clock),
        .reset    (reset),
        .clear    (state_next != state_q),
        .enable   (waiting),
        .timed_out(timed_out)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            fault_q       <= 1'b0;
            cycle_count_q <= '0;
            instret_q     <= '0;
        end else begin
            state_q <= state_next;
            if (fault_set) begin
                fault_q <= 1'b1;
            end
            if (state_q != ST_IDLE && state_q != ST_HALT) begin
                cycle_count_q <= cycle_count_q + COUNT_BITS'(1);
            end
            if (pc_load_c) begin
                instret_q <= instret_q + COUNT_BITS'(1);
            end
        end
    end

    always_comb begin
        state_next = state_q;
        fault_set  = 1'b0;
        waiting    = 1'b0;
        imem_req_c = 1'b0;
        ir_load_c  = 1'b0;
        dmem_req_c = 1'b0;
        mem_wEn_c  = 1'b0;
        rf_wEn_c   = 1'b0;
        pc_load_c  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                imem_req_c = 1'b1;
                if (imem_ready) begin
                    ir_load_c  = 1'b1;
                    state_next = ST_DECODE;
                end else if (timed_out) begin
                    state_next = ST_HALT;
                    fault_set  = 1'b1;
                end else begin
                    waiting = 1'b1;
                end
            end
            ST_DECODE: begin
                if (opcode == OP_SYSTEM) begin
                    state_next = ST_HALT;
                end else if (!is_legal_opcode(opcode)) begin
                    state_next = ST_HALT;
                    fault_set  = 1'b1;
                end else begin
                    state_next = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                if (opcode == OP_LOAD || opcode == OP_STORE) begin
                    state_next = ST_MEMORY;
                end else if (opcode == OP_BRANCH) begin
                    pc_load_c  = 1'b1;
                    state_next = ST_FETCH;
                end else begin
                    state_next = ST_WRITEBACK;
                end
            end
            ST_MEMORY: begin
                dmem_req_c = 1'b1;
                mem_wEn_c  = decode_mem_wEn & dmem_ready & (opcode == OP_STORE);
                if (dmem_ready) begin
                    if (opcode == OP_STORE) begin
                        pc_load_c  = 1'b1;
                        state_next = ST_FETCH;
                    end else begin
                        state_next = ST_WRITEBACK;
                    end
                end else if (timed_out) begin
                    state_next = ST_HALT;
                    fault_set  = 1'b1;
                end else begin
                    waiting = 1'b1;
                end
            end
            ST_WRITEBACK: begin
                rf_wEn_c   = decode_wEn;
                pc_load_c  = 1'b1;
                state_next = ST_FETCH;
            end
            ST_HALT: begin
                state_next = ST_HALT;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // A reset landing mid-instruction must not leak a final write or PC update.
        if (reset) begin
            imem_req_c = 1'b0;
            ir_load_c  = 1'b0;
            dmem_req_c = 1'b0;
            mem_wEn_c  = 1'b0;
            rf_wEn_c   = 1'b0;
            pc_load_c  = 1'b0;
        end
    end

    assign imem_req    = imem_req_c;
    assign ir_load     = ir_load_c;
    assign dmem_req    = dmem_req_c;
    assign mem_wEn     = mem_wEn_c;
    assign rf_wEn      = rf_wEn_c;
    assign pc_load     = pc_load_c;
    assign state       = state_q;
    assign halted      = (state_q == ST_HALT);
    assign fault       = fault_q;
    assign cycle_count = cycle_count_q;
    assign instret     = instret_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench for multicycle_sequencer: a per-instruction latency model
// predicts retire/halt events which a decoupled monitor checks.
module tb_multicycle_sequencer;

    localparam int COUNT_BITS  = 32;
    localparam int MEM_TIMEOUT = 15;

    logic                  clock = 1'b0;
    logic                  reset, start;
    logic [6:0]            opcode;
    logic                  decode_wEn, decode_mem_wEn, imem_ready, dmem_ready;
    logic                  imem_req, ir_load, dmem_req, mem_wEn, rf_wEn, pc_load;
    logic [2:0]            state;
    logic                  halted, fault;
    logic [COUNT_BITS-1:0] cycle_count, instret;

    multicycle_sequencer #(
        .COUNT_BITS (COUNT_BITS),
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .opcode        (opcode),
        .decode_wEn    (decode_wEn),
        .decode_mem_wEn(decode_mem_wEn),
        .imem_ready    (imem_ready),
        .dmem_ready    (dmem_ready),
        .imem_req      (imem_req),
        .ir_load       (ir_load),
        .dmem_req      (dmem_req),
        .mem_wEn       (mem_wEn),
        .rf_wEn        (rf_wEn),
        .pc_load       (pc_load),
        .state         (state),
        .halted        (halted),
        .fault         (fault),
        .cycle_count   (cycle_count),
        .instret       (instret)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [6:0] op;
        bit         wen;
        bit         mwen;
        int         ilat;
        int         dlat;
    } instr_t;

    typedef struct {
        bit is_halt;
        int cycles;
        int rf;
        int mw;
        bit fault;
        int instret;
        int ccount;
    } exp_t;

    logic [6:0] legal_ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                  7'b1100011, 7'b1101111, 7'b1100111, 7'b0010111, 7'b0110111};

    instr_t prog[$];
    exp_t   sb[$];
    int     checks = 0;
    int     errors = 0;
    bit     active = 0;
    int     model_total, model_retired;
    bit     model_fault;
    int     acc_cyc, acc_rf, acc_mw;
    bit     halt_seen;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic bit isLegal(input logic [6:0] op);
        bit found = 0;
        foreach (legal_ops[k]) if (legal_ops[k] == op) found = 1;
        return found;
    endfunction

    // Latency rule per instruction: fetch wait + fixed stage cost + data wait.
    function automatic exp_t modelInstr(input instr_t in);
        exp_t e;
        int   fetch_cycles;
        e = '{default: 0};
        fetch_cycles = (in.ilat > MEM_TIMEOUT) ? MEM_TIMEOUT + 1 : in.ilat + 1;
        if (in.ilat > MEM_TIMEOUT) begin
            e.is_halt = 1; e.fault = 1; e.cycles = fetch_cycles;
        end else if (in.op == 7'b1110011) begin
            e.is_halt = 1; e.cycles = fetch_cycles + 1;
        end else if (!isLegal(in.op)) begin
            e.is_halt = 1; e.fault = 1; e.cycles = fetch_cycles + 1;
        end else if (in.op == 7'b1100011) begin
            e.cycles = fetch_cycles + 2;
        end else if (in.op == 7'b0000011 || in.op == 7'b0100011) begin
            if (in.dlat > MEM_TIMEOUT) begin
                e.is_halt = 1; e.fault = 1; e.cycles = fetch_cycles + 2 + MEM_TIMEOUT + 1;
            end else if (in.op == 7'b0100011) begin
                e.cycles = fetch_cycles + 2 + in.dlat + 1; e.mw = int'(in.mwen);
            end else begin
                e.cycles = fetch_cycles + 2 + in.dlat + 2; e.rf = int'(in.wen);
            end
        end else begin
            e.cycles = fetch_cycles + 3; e.rf = int'(in.wen);
        end
        e.instret = model_retired;
        if (e.is_halt) begin
            e.ccount    = model_total + e.cycles;
            model_fault = e.fault;
        end else begin
            e.ccount = model_total + e.cycles - 1;
            model_retired++;
        end
        model_total += e.cycles;
        return e;
    endfunction

    task automatic doReset();
        @(negedge clock);
        reset = 1; start = 0; imem_ready = 0; dmem_ready = 0;
        repeat (2) @(posedge clock);
        @(negedge clock); #1;
        checkOutput("reset_state", state, 0);
        checkOutput("reset_strobes", {imem_req, ir_load, dmem_req, mem_wEn, rf_wEn, pc_load}, 0);
        checkOutput("reset_halted_fault", {halted, fault}, 0);
        checkOutput("reset_cycle_count", cycle_count, 0);
        checkOutput("reset_instret", instret, 0);
        reset = 0;
    endtask

    task automatic loadInstr(input int idx, output int il, output int dl);
        il = 0; dl = 0;
        if (idx < prog.size()) begin
            opcode = prog[idx].op; decode_wEn = prog[idx].wen; decode_mem_wEn = prog[idx].mwen;
            il = prog[idx].ilat; dl = prog[idx].dlat;
        end
    endtask

    // Runs the program in prog from reset; acts as the variable-latency memories.
    task automatic applyStimulus(input string tag);
        exp_t last;
        int   idx, iwait, dwait, il, dl;
        bit   retire_pending, done;
        sb.delete(); model_total = 0; model_retired = 0; model_fault = 0;
        last = '{default: 0};
        foreach (prog[k]) begin
            last = modelInstr(prog[k]);
            sb.push_back(last);
        end
        doReset();
        @(negedge clock); start = 1;
        @(posedge clock); #1; start = 0; active = 1;
        idx = 0; loadInstr(idx, il, dl);
        iwait = 0; dwait = 0; retire_pending = 0; done = 0;
        for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
            @(negedge clock);
            if (retire_pending) begin
                idx++; loadInstr(idx, il, dl);
                iwait = 0; dwait = 0; retire_pending = 0;
            end
            imem_ready = imem_req && (iwait == il);
            if (imem_req && !imem_ready) iwait++;
            dmem_ready = dmem_req && (dwait == dl);
            if (dmem_req && !dmem_ready) dwait++;
            #1;
            if (pc_load) retire_pending = 1;
            if (halted) done = 1;
        end
        if (!done) begin
            checks++; errors++;
            $display("[TB] FAIL %s_halt_timeout: halted=0 after 2000 cycles, expected halted=1", tag);
        end else begin
            repeat (4) @(negedge clock);
            #3;
            checkOutput({tag, "_halted"}, halted, 1);
            checkOutput({tag, "_state"}, state, 6);
            checkOutput({tag, "_fault"}, fault, model_fault);
            checkOutput({tag, "_frozen_cycle_count"}, cycle_count, last.ccount);
            checkOutput({tag, "_frozen_instret"}, instret, last.instret);
            checkOutput({tag, "_halt_strobes"}, {imem_req, ir_load, dmem_req, mem_wEn, rf_wEn, pc_load}, 0);
        end
        checkOutput({tag, "_sb_drained"}, sb.size(), 0);
        active = 0;
    endtask

    task automatic resetMidMemory();
        bit seen = 0;
        doReset();
        opcode = 7'b0100011; decode_wEn = 1; decode_mem_wEn = 1; imem_ready = 1; dmem_ready = 0;
        @(negedge clock); start = 1;
        @(posedge clock); #1; start = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clock); #1;
            if (dmem_req) seen = 1;
        end
        checkOutput("midmem_reached", seen, 1);
        reset = 1; dmem_ready = 1; #1;
        checkOutput("midmem_strobes_in_reset", {imem_req, ir_load, dmem_req, mem_wEn, rf_wEn, pc_load}, 0);
        @(negedge clock); #1;
        checkOutput("midmem_state", state, 0);
        checkOutput("midmem_cycle_count", cycle_count, 0);
        checkOutput("midmem_instret", instret, 0);
        checkOutput("midmem_halted_fault", {halted, fault}, 0);
        reset = 0; dmem_ready = 0; imem_ready = 0;
        @(negedge clock); #1;
        checkOutput("midmem_stays_idle", state, 0);
    endtask

    // Monitor: accumulates strobes per instruction and pops on each retire or halt.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock); #2;
            if (!active) begin
                acc_cyc = 0; acc_rf = 0; acc_mw = 0; halt_seen = 0;
            end else if (halted) begin
                if (!halt_seen) begin
                    halt_seen = 1;
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("[TB] FAIL sb_empty: halt observed with 0 queued, expected at least 1");
                    end else begin
                        e = sb.pop_front();
                        checkOutput("event_is_halt", 1, e.is_halt);
                        checkOutput("halt_cycles", acc_cyc, e.cycles);
                        checkOutput("halt_fault", fault, e.fault);
                        checkOutput("halt_cycle_count", cycle_count, e.ccount);
                        checkOutput("halt_instret", instret, e.instret);
                        checkOutput("halt_rf_pulses", acc_rf, e.rf);
                        checkOutput("halt_mw_pulses", acc_mw, e.mw);
                    end
                end
            end else begin
                acc_cyc++;
                acc_rf += int'(rf_wEn);
                acc_mw += int'(mem_wEn);
                if (pc_load) begin
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("[TB] FAIL sb_empty: retire observed with 0 queued, expected at least 1");
                    end else begin
                        e = sb.pop_front();
                        checkOutput("event_is_halt", 0, e.is_halt);
                        checkOutput("retire_cycles", acc_cyc, e.cycles);
                        checkOutput("retire_rf_pulses", acc_rf, e.rf);
                        checkOutput("retire_mw_pulses", acc_mw, e.mw);
                        checkOutput("retire_instret", instret, e.instret);
                        checkOutput("retire_cycle_count", cycle_count, e.ccount);
                    end
                    acc_cyc = 0; acc_rf = 0; acc_mw = 0;
                end
            end
        end
    end

    initial begin : driver
        instr_t in;
        int     n;
        reset = 1; start = 0; opcode = '0; decode_wEn = 0; decode_mem_wEn = 0;
        imem_ready = 0; dmem_ready = 0;

        prog.delete();
        prog.push_back('{7'b0110011, 1'b1, 1'b0, 0, 0});
        prog.push_back('{7'b0000011, 1'b1, 1'b0, 0, 3});
        prog.push_back('{7'b0100011, 1'b0, 1'b1, 0, 0});
        prog.push_back('{7'b1100011, 1'b0, 1'b0, 0, 0});
        prog.push_back('{7'b1110011, 1'b0, 1'b0, 0, 0});
        applyStimulus("directed");

        prog.delete();
        prog.push_back('{7'b0000000, 1'b1, 1'b1, 0, 0});
        applyStimulus("illegal");

        prog.delete();
        prog.push_back('{7'b0110011, 1'b1, 1'b0, MEM_TIMEOUT + 5, 0});
        applyStimulus("imem_timeout");

        for (int s = 0; s < 8; s++) begin
            prog.delete();
            n = $urandom_range(3, 10);
            for (int i = 0; i < n; i++) begin
                in.op   = legal_ops[$urandom_range(0, 8)];
                in.wen  = 1'($urandom_range(0, 1));
                in.mwen = 1'($urandom_range(0, 1));
                in.ilat = $urandom_range(0, 3);
                in.dlat = $urandom_range(0, 4);
                prog.push_back(in);
            end
            in.wen = 1; in.mwen = 1; in.ilat = $urandom_range(0, 2); in.dlat = 0;
            case (s % 4)
                0: in.op = 7'b1110011;
                1: begin
                    do in.op = 7'($urandom); while (isLegal(in.op) || in.op == 7'b1110011);
                end
                2: in.ilat = MEM_TIMEOUT + 1 + $urandom_range(0, 4);
                default: begin
                    in.op   = ($urandom_range(0, 1) != 0) ? 7'b0000011 : 7'b0100011;
                    in.dlat = MEM_TIMEOUT + 1;
                end
            endcase
            prog.push_back(in);
            applyStimulus("random");
        end

        resetMidMemory();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Multi-cycle control FSM for the RISC-V core.
- Sequences the fetch, decode, execute, memory and writeback stages so that one instruction is in flight at a time.
- Gates the enables that the decode unit produces (register-file write, memory write, PC update) so each fires exactly once per instruction.
- Handles variable-latency instruction/data memory through req/ready handshakes, halts on ecall or illegal opcode, and keeps cycle and retired-instruction counters.

Parameters:
- COUNT_BITS, 32, width of cycle_count and instret.
- MEM_TIMEOUT, 15, maximum cycles to wait for imem_ready or dmem_ready before faulting.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  leave IDLE and begin fetching.
- opcode  input  7  instruction[6:0] from the instruction register.
- decode_wEn  input  1  wEn from decode.
- decode_mem_wEn  input  1  mem_wEn from decode.
- imem_ready  input  1  instruction memory data valid.
- dmem_ready  input  1  data memory access complete.
- imem_req  output  1  instruction fetch request.
- ir_load  output  1  latch instruction into IR.
- dmem_req  output  1  data memory access request.
- mem_wEn  output  1  gated store enable.
- rf_wEn  output  1  gated register-file write.
- pc_load  output  1  update PC (fetch selects next_PC_select/target_PC).
- state  output  3  current FSM state.
- halted  output  1  core stopped.
- fault  output  1  halt caused by illegal opcode or timeout.
- cycle_count  output  COUNT_BITS  cycles since leaving IDLE.
- instret  output  COUNT_BITS  retired instructions.

Behaviour:
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEMORY=4, WRITEBACK=5, HALT=6.
- Reset: state=IDLE; halted=0, fault=0, cycle_count=0, instret=0, wait counter=0; all strobes low. Reset mid-instruction aborts with no pulse emitted that cycle.
- Strobes are combinational from the registered state plus handshake inputs; no strobe is ever asserted in IDLE or HALT.
- IDLE: start=1 moves to FETCH next cycle; otherwise remain in IDLE.
- FETCH:
  - imem_req=1.
  - When imem_ready=1: ir_load=1 that cycle, move to DECODE.
  - Otherwise increment the wait counter. If the counter has reached MEM_TIMEOUT and ready is still low, move to HALT with fault=1.
- DECODE:
  - opcode 1110011 (ecall) moves to HALT with fault=0.
  - Any opcode not in {0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0010111, 0110111} moves to HALT with fault=1.
  - Otherwise move to EXECUTE.
- EXECUTE:
  - 0000011 (load) or 0100011 (store) moves to MEMORY.
  - 1100011 (branch): pc_load=1, instret increments, move to FETCH.
  - All other opcodes move to WRITEBACK.
- MEMORY:
  - dmem_req=1.
  - mem_wEn = decode_mem_wEn & dmem_ready & (opcode==0100011).
  - When dmem_ready=1: a store asserts pc_load=1, increments instret and moves to FETCH; a load moves to WRITEBACK.
  - Timeout rule is the same as FETCH.
- WRITEBACK: rf_wEn=decode_wEn, pc_load=1, instret increments, move to FETCH. rf_wEn is exactly one cycle per instruction.
- Wait counter: clears on every state change; width is clog2(MEM_TIMEOUT+1).
- HALT: absorbing state, exited only by reset; halted=1.
- Counters:
  - cycle_count increments every cycle outside IDLE and HALT.
  - Both counters wrap modulo 2^COUNT_BITS with no saturation.
- Cycles per instruction with zero-wait memory (ready high in the first cycle): ALU/jal/jalr/lui/auipc 4, branch 3, store 4, load 5.

Decomposition:
- Shared package holds:
  - the state encodings;
  - opcode constants OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_AUIPC, OP_LUI, OP_SYSTEM.
- The decode unit reuses the same opcode constants.
- One sub-module: mem_wait_timer, a wait counter with clear/enable and a timeout flag, instantiated once and shared by FETCH and MEMORY.

Test Plan:
- ALU op: reset, start=1, ready held high, add (0110011), decode_wEn=1 → FETCH→DECODE→EXECUTE→WRITEBACK; rf_wEn and pc_load each high exactly 1 cycle; after 4 cycles instret=1, cycle_count=4.
- Load with latency: lw, dmem_ready low for 3 cycles → dmem_req high for 4 cycles; rf_wEn only in WRITEBACK; total 8 cycles.
- Store and branch: sw with decode_wEn=0 → mem_wEn high 1 cycle, rf_wEn never high. beq → 3 cycles, pc_load in EXECUTE.
- Halts: ecall (0x00000073) → HALT, halted=1, fault=0, counters frozen. Opcode 0000000 → fault=1.
- Timeout: imem_ready held low → HALT with fault=1 after MEM_TIMEOUT+1 FETCH cycles.
- Reset mid-MEMORY: state=IDLE next cycle, counters 0, no strobe pulses.
